// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Two-requester round-robin arbiter for the core's single shared memory
//   port. Requester 0 is instruction fetch and requester 1 is load/store.
//   The arbiter drives the select line of the address/write-data muxes. It
//   sequences each transaction with a request/acknowledge handshake. A
//   watchdog completes a stalled transaction with an error-flagged ack.
//
// Ports:
//   CLOCK_50, RESET_InLow       clock, asynchronous active-low reset
//   ARB_Req/Addr/WData/We{0,1}  requester-side transaction inputs
//   ARB_Ack{0,1}_Out            per-requester completion strobe
//   ARB_Err{0,1}_Out            timeout flag, qualified by the matching ack
//   ARB_RData_OutBUS            read data, valid while either ack is high
//   ARB_Sel_Out                 mux select (0 = requester 0, 1 = requester 1)
//   MEM_Req/Addr/WData/We_Out   muxed memory-side request
//   MEM_Ack_In, MEM_RData_InBUS memory completion strobe and read data
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_InLow,
    input  logic                  ARB_Req0_In,
    input  logic [ADDR_WIDTH-1:0] ARB_Addr0_InBUS,
    input  logic [DATA_WIDTH-1:0] ARB_WData0_InBUS,
    input  logic                  ARB_We0_In,
    input  logic                  ARB_Req1_In,
    input  logic [ADDR_WIDTH-1:0] ARB_Addr1_InBUS,
    input  logic [DATA_WIDTH-1:0] ARB_WData1_InBUS,
    input  logic                  ARB_We1_In,
    output logic                  ARB_Ack0_Out,
    output logic                  ARB_Ack1_Out,
    output logic                  ARB_Err0_Out,
    output logic                  ARB_Err1_Out,
    output logic [DATA_WIDTH-1:0] ARB_RData_OutBUS,
    output logic                  ARB_Sel_Out,
    output logic                  MEM_Req_Out,
    output logic [ADDR_WIDTH-1:0] MEM_Addr_OutBUS,
    output logic [DATA_WIDTH-1:0] MEM_WData_OutBUS,
    output logic                  MEM_We_Out,
    input  logic                  MEM_Ack_In,
    input  logic [DATA_WIDTH-1:0] MEM_RData_InBUS
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;

    logic busy;
    logic timeout;
    logic done;

    // Outputs are pure decodes of the registered state and live inputs, so
    // they fall the instant reset asserts and no ack can leak from an
    // abandoned transaction.
    assign busy    = (state == BUSY0) || (state == BUSY1);
    assign timeout = busy && !MEM_Ack_In && (cnt == CNT_LAST);
    assign done    = busy && (MEM_Ack_In || timeout);

    assign ARB_Sel_Out      = (state == BUSY1);
    assign MEM_Req_Out      = busy;
    assign MEM_Addr_OutBUS  = ARB_Sel_Out ? ARB_Addr1_InBUS  : ARB_Addr0_InBUS;
    assign MEM_WData_OutBUS = ARB_Sel_Out ? ARB_WData1_InBUS : ARB_WData0_InBUS;
    assign MEM_We_Out       = busy && (ARB_Sel_Out ? ARB_We1_In : ARB_We0_In);

    assign ARB_Ack0_Out     = (state == BUSY0) && done;
    assign ARB_Ack1_Out     = (state == BUSY1) && done;
    assign ARB_Err0_Out     = (state == BUSY0) && timeout;
    assign ARB_Err1_Out     = (state == BUSY1) && timeout;
    // A timeout completion returns zero data; a real memory ack wins.
    assign ARB_RData_OutBUS = (busy && MEM_Ack_In) ? MEM_RData_InBUS : '0;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
        if (!RESET_InLow) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;   // port 0 wins the first tie
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    // On a tie, the port that was not granted last goes next.
                    if (ARB_Req0_In && (!ARB_Req1_In || last_grant)) begin
                        state      <= BUSY0;
                        last_grant <= 1'b0;
                    end else if (ARB_Req1_In) begin
                        state      <= BUSY1;
                        last_grant <= 1'b1;
                    end
                end
                BUSY0, BUSY1: begin
                    // Completion also covers a requester that dropped Req
                    // mid-transaction: the ack is issued regardless.
                    if (done) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        // Cannot wrap: reaching CNT_LAST forces done.
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester, round-robin arbiter for the core's single shared memory port: requester 0 is instruction fetch, requester 1 is load/store.
- Owns the select line of the address/write-data 2:1 multiplexers in front of the memory port.
- Sequences each transaction with a request/acknowledge handshake and enforces a bounded-latency watchdog.
- Returns an error-flagged acknowledge when memory never answers.

Parameters:
- ADDR_WIDTH, 32, width of the address buses.
- DATA_WIDTH, 32, width of the write-data and read-data buses.
- TIMEOUT_CYCLES, 16, maximum BUSY cycles before a forced error completion; legal range is 2 or more.

Ports:
- CLOCK_50  input  1  system clock; all state changes on the rising edge.
- RESET_InLow  input  1  asynchronous, active-low reset.
- ARB_Req0_In  input  1  requester 0 transaction request; level-held until acknowledged.
- ARB_Addr0_InBUS  input  ADDR_WIDTH  requester 0 address.
- ARB_WData0_InBUS  input  DATA_WIDTH  requester 0 write data.
- ARB_We0_In  input  1  requester 0 write enable.
- ARB_Req1_In  input  1  requester 1 transaction request.
- ARB_Addr1_InBUS  input  ADDR_WIDTH  requester 1 address.
- ARB_WData1_InBUS  input  DATA_WIDTH  requester 1 write data.
- ARB_We1_In  input  1  requester 1 write enable.
- ARB_Ack0_Out  output  1  completion strobe to requester 0.
- ARB_Ack1_Out  output  1  completion strobe to requester 1.
- ARB_Err0_Out  output  1  timeout flag, qualified by ARB_Ack0_Out.
- ARB_Err1_Out  output  1  timeout flag, qualified by ARB_Ack1_Out.
- ARB_RData_OutBUS  output  DATA_WIDTH  read data; valid while either ack is high.
- ARB_Sel_Out  output  1  mux select: 0 selects requester 0, 1 selects requester 1.
- MEM_Req_Out  output  1  memory port request.
- MEM_Addr_OutBUS  output  ADDR_WIDTH  muxed address.
- MEM_WData_OutBUS  output  DATA_WIDTH  muxed write data.
- MEM_We_Out  output  1  muxed write enable, gated by MEM_Req_Out.
- MEM_Ack_In  input  1  memory completion strobe.
- MEM_RData_InBUS  input  DATA_WIDTH  memory read data.

Behaviour:
- Reset: while RESET_InLow=0, asynchronously force the following:
  - state=IDLE, watchdog counter=0, last_grant=1 (so port 0 wins the first tie).
  - MEM_Req_Out=0, MEM_We_Out=0, ARB_Sel_Out=0.
  - all Ack and Err outputs 0.
  - A reset mid-transaction abandons it silently; no ack is issued.
- FSM states: IDLE, BUSY0, BUSY1. The state is registered; all outputs are combinational decodes of state and inputs.
- IDLE:
  - Only Req0 high: next state BUSY0.
  - Only Req1 high: next state BUSY1.
  - Both high: grant the port that is not last_grant, then update last_grant to the granted port.
  - Neither high: stay in IDLE.
  - MEM_Ack_In is ignored in IDLE.
- BUSYx:
  - MEM_Req_Out=1; ARB_Sel_Out=x.
  - MEM_Addr, MEM_WData and MEM_We follow requester x's live inputs, so the requester must hold them stable until its ack.
- Completion, in the same cycle that MEM_Ack_In=1 while in BUSYx:
  - ARB_Ackx_Out=1 and ARB_RData_OutBUS=MEM_RData_InBUS.
  - Next state IDLE; counter cleared.
  - The requester deasserts or re-presents Req on the following cycle.
- Latency: request high in cycle N (IDLE), then BUSY and MEM_Req_Out high in cycle N+1. Minimum transaction is 2 cycles. One IDLE cycle always separates back-to-back grants.
- Watchdog:
  - Counter clears on entering BUSY and increments on each BUSY cycle without MEM_Ack_In.
  - Timeout when counter==TIMEOUT_CYCLES-1 and MEM_Ack_In=0: ARB_Ackx_Out=1, ARB_Errx_Out=1, ARB_RData_OutBUS=0, next state IDLE.
  - Timeout therefore fires on the TIMEOUT_CYCLES-th BUSY cycle.
  - If MEM_Ack_In=1 in that same cycle, it is a normal completion (ack wins, Err=0).
  - Counter width is clog2(TIMEOUT_CYCLES); it never wraps.
- Outside a matching BUSY state, Ack, Err and RData are all 0. ARB_Sel_Out=0 in IDLE.
- Requester drops Req while in BUSY: this is a protocol violation. The arbiter does not abort; it completes on MEM_Ack_In or timeout and issues the ack regardless.
- The non-granted requester waits with no ack. Starvation is bounded to one transaction by round-robin.

Test Plan:
- Reset then Req0=1, Addr0=0x100, We0=0; memory acks on the 2nd BUSY cycle with RData=0xDEADBEEF -> MEM_Req_Out high cycles 1-2, Sel=0, Ack0 pulses in cycle 2 with RData=0xDEADBEEF, Err0=0.
- Req0 and Req1 both held continuously, memory acks immediately -> grants alternate 0,1,0,1; Sel toggles accordingly; each grant separated by one IDLE cycle.
- Req1=1, We1=1, Addr1=0x2000, WData1=0x12345678 -> MEM_We_Out=1, MEM_Addr=0x2000, MEM_WData=0x12345678, Sel=1 while BUSY1; MEM_We_Out=0 in IDLE.
- TIMEOUT_CYCLES=16, Req0 with MEM_Ack_In held 0 -> Ack0=1, Err0=1, RData=0 on the 16th BUSY cycle, then IDLE; a repeat with MEM_Ack_In=1 on exactly that cycle -> Ack0=1, Err0=0.
- Assert RESET_InLow=0 mid-BUSY1 between clock edges -> MEM_Req_Out, Sel and Ack drop immediately; after release, a simultaneous Req0/Req1 grants port 0 first.
- MEM_Ack_In pulsed while IDLE with no requests -> no Ack or Err on either port, state remains IDLE.
